// File: rtl/pmu_domain_ctrl_if.sv
// Request handshake and domain clock/enable bundle for pmu_domain_ctrl.
interface pmu_domain_ctrl_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int LEVEL_W     = 3,
  parameter int SEL_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
);
  logic                   change_level_flag;
  logic [LEVEL_W-1:0]     change_level;
  logic                   change_power_mode_flag;
  logic [1:0]             change_power_mode;
  logic [SEL_W-1:0]       domain_sel;
  logic [NUM_DOMAINS-1:0] domain_activity;
  logic [NUM_DOMAINS-1:0] power_domain_clk;
  logic [NUM_DOMAINS-1:0] power_domain_en;
  logic                   busy;
  logic                   req_ack;
  logic                   req_err;

  modport master (
    output change_level_flag, change_level, change_power_mode_flag,
           change_power_mode, domain_sel, domain_activity,
    input  power_domain_clk, power_domain_en, busy, req_ack, req_err
  );

  modport slave (
    input  change_level_flag, change_level, change_power_mode_flag,
           change_power_mode, domain_sel, domain_activity,
    output power_domain_clk, power_domain_en, busy, req_ack, req_err
  );
endinterface

// File: rtl/pmu_domain_ctrl.sv
// Multi-domain glitch-free clock divider and power-mode controller with a shared request FSM.
// Build macro PMU_AUTOIDLE_EN adds per-domain inactivity clock gating.
module pmu_domain_ctrl #(
  parameter int NUM_DOMAINS   = 4,
  parameter int LEVEL_W       = 3,
  parameter int MAX_LEVEL     = 6,
  parameter int DEFAULT_LEVEL = 0,
  parameter int IDLE_TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             reset,
  pmu_domain_ctrl_if.slave pmu_if
);
  localparam int CNT_W = MAX_LEVEL + 1;
  localparam int SEL_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PENDING = 2'd1, S_APPLY = 2'd2} state_e;
  typedef enum logic [1:0] {M_RUN = 2'd0, M_IDLE = 2'd1, M_OFF = 2'd2} mode_e;

  function automatic mode_e norm_mode(input logic [1:0] m);
    if (m == 2'd3) norm_mode = M_RUN;
    else           norm_mode = mode_e'(m);
  endfunction

  function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] l);
    if (int'(l) > MAX_LEVEL) clamp_level = LEVEL_W'(MAX_LEVEL);
    else                     clamp_level = l;
  endfunction

  function automatic logic [CNT_W-1:0] half_max(input logic [LEVEL_W-1:0] l);
    half_max = (CNT_W'(1) << l) - CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic [LEVEL_W-1:0] new_lvl_q, new_lvl_d;
  mode_e              new_mode_q, new_mode_d;
  logic               do_lvl_q, do_lvl_d, do_mode_q, do_mode_d;
  logic               busy_q, busy_d, ack_q, ack_d, err_q, err_d;

  logic [LEVEL_W-1:0]     lvl_q  [NUM_DOMAINS];
  logic [LEVEL_W-1:0]     lvl_d  [NUM_DOMAINS];
  mode_e                  mode_q [NUM_DOMAINS];
  mode_e                  mode_d [NUM_DOMAINS];
  logic [CNT_W-1:0]       cnt_q  [NUM_DOMAINS];
  logic [CNT_W-1:0]       cnt_d  [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] dclk_q, dclk_d, en_q, en_d;

  logic [NUM_DOMAINS-1:0] run_safe_s, gated_s, safe_s;
  logic                   any_flag_s, sel_ok_s, tgt_safe_s, apply_s, freeze_s;

  assign any_flag_s = pmu_if.change_level_flag | pmu_if.change_power_mode_flag;
  assign sel_ok_s   = (int'(pmu_if.domain_sel) < NUM_DOMAINS);
  assign tgt_safe_s = safe_s[tgt_q];
  assign freeze_s   = (state_q == S_PENDING) && tgt_safe_s;

  // Safe point: counter just wrapped with the clock low, or the domain is already gated.
  always_comb begin
    run_safe_s = {NUM_DOMAINS{1'b0}};
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      run_safe_s[i] = (cnt_q[i] == CNT_W'(0)) && !dclk_q[i];
    end
  end

`ifdef PMU_AUTOIDLE_EN
  localparam int IC_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IC_W-1:0]        idle_cnt_q [NUM_DOMAINS];
  logic [IC_W-1:0]        idle_cnt_d [NUM_DOMAINS];
  logic [NUM_DOMAINS-1:0] ai_q, ai_d;

  // Inactivity timer; the gate closes only at the domain's next safe point.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    ai_d       = ai_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      if (pmu_if.domain_activity[i] || (mode_q[i] != M_RUN)) begin
        idle_cnt_d[i] = IC_W'(0);
        ai_d[i]       = 1'b0;
      end else if (int'(idle_cnt_q[i]) >= IDLE_TIMEOUT) begin
        idle_cnt_d[i] = idle_cnt_q[i];
        ai_d[i]       = ai_q[i] | run_safe_s[i];
      end else begin
        idle_cnt_d[i] = idle_cnt_q[i] + IC_W'(1);
        ai_d[i]       = ai_q[i];
      end
    end
  end

  // Auto-idle state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOMAINS; i++) idle_cnt_q[i] <= IC_W'(0);
      ai_q <= {NUM_DOMAINS{1'b0}};
    end else begin
      idle_cnt_q <= idle_cnt_d;
      ai_q       <= ai_d;
    end
  end

  // Holding on the closing edge as well keeps the counter parked at zero for the restart.
  always_comb begin
    gated_s = ai_q | ai_d;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      gated_s[i] = gated_s[i] | (mode_q[i] != M_RUN);
    end
  end
`else
  // Only the mode register gates a domain in this build.
  always_comb begin
    gated_s = {NUM_DOMAINS{1'b0}};
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      gated_s[i] = (mode_q[i] != M_RUN);
    end
  end
`endif

  assign safe_s = run_safe_s | gated_s;

  // Request FSM next-state and handshake outputs.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    new_lvl_d  = new_lvl_q;
    new_mode_d = new_mode_q;
    do_lvl_d   = do_lvl_q;
    do_mode_d  = do_mode_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    apply_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_flag_s && sel_ok_s) begin
          state_d    = S_PENDING;
          tgt_d      = pmu_if.domain_sel;
          new_lvl_d  = clamp_level(pmu_if.change_level);
          new_mode_d = norm_mode(pmu_if.change_power_mode);
          do_lvl_d   = pmu_if.change_level_flag;
          do_mode_d  = pmu_if.change_power_mode_flag;
          busy_d     = 1'b1;
        end else if (any_flag_s) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PENDING: begin
        err_d = any_flag_s;
        if (tgt_safe_s) state_d = S_APPLY;
        else            state_d = S_PENDING;
      end
      S_APPLY: begin
        err_d   = any_flag_s;
        apply_s = 1'b1;
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Request FSM registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= SEL_W'(0);
      new_lvl_q  <= LEVEL_W'(DEFAULT_LEVEL);
      new_mode_q <= M_RUN;
      do_lvl_q   <= 1'b0;
      do_mode_q  <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      new_lvl_q  <= new_lvl_d;
      new_mode_q <= new_mode_d;
      do_lvl_q   <= do_lvl_d;
      do_mode_q  <= do_mode_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Per-domain dividers; the target stays parked low from its safe point until the apply.
  always_comb begin
    lvl_d  = lvl_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    dclk_d = dclk_q;
    en_d   = en_q;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      en_d[i] = (mode_q[i] != M_OFF);
      if (apply_s && (tgt_q == SEL_W'(i))) begin
        if (do_lvl_q) lvl_d[i] = new_lvl_q;
        else          lvl_d[i] = lvl_q[i];
        if (do_mode_q) begin
          mode_d[i] = new_mode_q;
          if (new_mode_q != M_OFF) en_d[i] = 1'b1;
          else                     en_d[i] = (mode_q[i] != M_OFF);
        end else begin
          mode_d[i] = mode_q[i];
        end
        cnt_d[i]  = CNT_W'(0);
        dclk_d[i] = 1'b0;
      end else if (gated_s[i] || (freeze_s && (tgt_q == SEL_W'(i)))) begin
        cnt_d[i]  = cnt_q[i];
        dclk_d[i] = 1'b0;
      end else if (cnt_q[i] == half_max(lvl_q[i])) begin
        cnt_d[i]  = CNT_W'(0);
        dclk_d[i] = ~dclk_q[i];
      end else begin
        cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        dclk_d[i] = dclk_q[i];
      end
    end
  end

  // Per-domain state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOMAINS; i++) begin
        lvl_q[i]  <= LEVEL_W'(DEFAULT_LEVEL);
        mode_q[i] <= M_RUN;
        cnt_q[i]  <= CNT_W'(0);
      end
      dclk_q <= {NUM_DOMAINS{1'b0}};
      en_q   <= {NUM_DOMAINS{1'b1}};
    end else begin
      lvl_q  <= lvl_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      dclk_q <= dclk_d;
      en_q   <= en_d;
    end
  end

  assign pmu_if.power_domain_clk = dclk_q;
  assign pmu_if.power_domain_en  = en_q;
  assign pmu_if.busy             = busy_q;
  assign pmu_if.req_ack          = ack_q;
  assign pmu_if.req_err          = err_q;
endmodule
